// File: rtl/rx_descrambler_lock.sv
// 64b/66b receive block-lock FSM with self-synchronizing x^58 + x^39 + 1 descrambler.
// Requests single-bit gearbox slips on bad header alignment; all outputs registered.
module rx_descrambler_lock #(
    parameter int RX_DATA_WIDTH  = 64,
    parameter int SH_CNT_MAX     = 64,
    parameter int SH_INVALID_MAX = 16,
    parameter int SLIP_WAIT      = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [RX_DATA_WIDTH+1:0]   data_in,
    input  logic                       data_valid,
    output logic [RX_DATA_WIDTH-1:0]   data_out,
    output logic [1:0]                 sync_out,
    output logic                       valid_out,
    output logic                       slip,
    output logic                       locked,
    output logic                       header_err
);

    localparam int SCW = $clog2(SH_CNT_MAX + 1);
    localparam int IW  = $clog2(SH_INVALID_MAX + 1);
    localparam int WW  = $clog2(SLIP_WAIT + 1);

    localparam logic [SCW-1:0] SH_MAX_C  = SCW'(SH_CNT_MAX);
    localparam logic [IW-1:0]  INV_MAX_C = IW'(SH_INVALID_MAX);
    localparam logic [WW-1:0]  WAIT_C    = WW'(SLIP_WAIT);

    typedef enum logic [1:0] {
        HUNT      = 2'd0,
        SLIP_HOLD = 2'd1,
        LOCKED    = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [SCW-1:0]     sh_cnt_reg, sh_cnt_next, sh_inc;
    logic [IW-1:0]      inv_cnt_reg, inv_cnt_next, inv_inc;
    logic [WW-1:0]      wait_cnt_reg, wait_cnt_next, wait_inc;
    logic               slip_next;
    logic [57:0]        scr_reg;
    logic [1:0]         hdr;
    logic               hdr_bad;

    logic [RX_DATA_WIDTH-1:0] desc;
    logic [57:0]              s_chain [RX_DATA_WIDTH+1];

    assign hdr     = data_in[RX_DATA_WIDTH+1:RX_DATA_WIDTH];
    assign hdr_bad = (hdr[1] == hdr[0]);

    assign sh_inc   = sh_cnt_reg + SCW'(1);
    assign inv_inc  = inv_cnt_reg + IW'(hdr_bad);
    assign wait_inc = wait_cnt_reg + WW'(1);

    // Bit-serial descrambler unrolled MSB-first; the received bit feeds the state.
    assign s_chain[0] = scr_reg;

    genvar gi;
    generate
        for (gi = 0; gi < RX_DATA_WIDTH; gi++) begin : g_bit
            assign desc[RX_DATA_WIDTH-1-gi] = data_in[RX_DATA_WIDTH-1-gi]
                                              ^ s_chain[gi][38] ^ s_chain[gi][57];
            assign s_chain[gi+1] = {s_chain[gi][56:0], data_in[RX_DATA_WIDTH-1-gi]};
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        sh_cnt_next   = sh_cnt_reg;
        inv_cnt_next  = inv_cnt_reg;
        wait_cnt_next = wait_cnt_reg;
        slip_next     = 1'b0;
        if (data_valid) begin
            case (state_reg)
                HUNT: begin
                    if (hdr_bad) begin
                        slip_next   = 1'b1;
                        sh_cnt_next = '0;
                        state_next  = SLIP_HOLD;
                    end else if (sh_inc == SH_MAX_C) begin
                        state_next   = LOCKED;
                        sh_cnt_next  = '0;
                        inv_cnt_next = '0;
                    end else begin
                        sh_cnt_next = sh_inc;
                    end
                end
                SLIP_HOLD: begin
                    if (wait_inc == WAIT_C) begin
                        wait_cnt_next = '0;
                        state_next    = HUNT;
                    end else begin
                        wait_cnt_next = wait_inc;
                    end
                end
                LOCKED: begin
                    // Loss of lock takes priority over a window rollover on the same block.
                    if (inv_inc == INV_MAX_C) begin
                        state_next    = SLIP_HOLD;
                        slip_next     = 1'b1;
                        sh_cnt_next   = '0;
                        inv_cnt_next  = '0;
                        wait_cnt_next = '0;
                    end else if (sh_inc == SH_MAX_C) begin
                        sh_cnt_next  = '0;
                        inv_cnt_next = '0;
                    end else begin
                        sh_cnt_next  = sh_inc;
                        inv_cnt_next = inv_inc;
                    end
                end
                default: begin
                    state_next    = HUNT;
                    sh_cnt_next   = '0;
                    inv_cnt_next  = '0;
                    wait_cnt_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= HUNT;
            sh_cnt_reg   <= '0;
            inv_cnt_reg  <= '0;
            wait_cnt_reg <= '0;
            scr_reg      <= '1;
            data_out     <= '0;
            sync_out     <= '0;
            valid_out    <= 1'b0;
            slip         <= 1'b0;
            locked       <= 1'b0;
            header_err   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            sh_cnt_reg   <= sh_cnt_next;
            inv_cnt_reg  <= inv_cnt_next;
            wait_cnt_reg <= wait_cnt_next;
            valid_out    <= data_valid && (state_reg == LOCKED);
            slip         <= slip_next;
            locked       <= (state_next == LOCKED);
            header_err   <= data_valid && hdr_bad;
            if (data_valid) begin
                scr_reg  <= s_chain[RX_DATA_WIDTH];
                data_out <= desc;
                sync_out <= hdr;
            end
        end
    end

endmodule

// File: doc/rx_descrambler_lock.md
# rx_descrambler_lock

Receive-side counterpart of the 64b/66b TX scrambler. Takes 66-bit blocks from the RX gearbox and checks the 2-bit sync headers to reach block lock. It asks the gearbox to slip by one bit when the header alignment is wrong. Once locked, it removes the self-synchronizing x^58 + x^39 + 1 scrambling and passes the descrambled 64-bit payload and sync header to the RX decoder.

## Interface
- RX_DATA_WIDTH, 64, payload width per block; block width is RX_DATA_WIDTH+2.
- SH_CNT_MAX, 64, number of headers in a lock-test window.
- SH_INVALID_MAX, 16, number of invalid headers in one window that causes loss of lock.
- SLIP_WAIT, 32, number of valid blocks ignored after a slip request.

Ports:
- clk  in  1  single clock for the whole block.
- rst_n  in  1  asynchronous, active-low reset.
- data_in  in  RX_DATA_WIDTH+2  [RX_DATA_WIDTH+1:RX_DATA_WIDTH] is the sync header; [RX_DATA_WIDTH-1] is the first-transmitted scrambled bit.
- data_valid  in  1  data_in carries a block this cycle.
- data_out  out  RX_DATA_WIDTH  descrambled payload, same bit order as data_in.
- sync_out  out  2  sync header of the block in data_out.
- valid_out  out  1  data_out and sync_out are valid and were taken while locked.
- slip  out  1  one-cycle pulse asking the gearbox to shift alignment by 1 bit.
- locked  out  1  block lock achieved.
- header_err  out  1  one-cycle pulse: the block just accepted had header 2'b00 or 2'b11.

## Operation
- Header check:
  - 2'b01 and 2'b10 are valid headers.
  - 2'b00 and 2'b11 are invalid.
- Descrambler state: 58-bit register s, reset to all ones.
- Bit processing: for each valid block, process bits from data_in[RX_DATA_WIDTH-1] down to [0]:
  - out_bit = in_bit ^ s[38] ^ s[57]
  - then s = {s[56:0], in_bit}. The received (scrambled) bit is shifted in, not the output bit.
- The header bits are never scrambled and are never shifted into s.
- s advances only on data_valid, in every FSM state, so the descrambler is synchronized by the time lock is declared.
- FSM states: HUNT, SLIP_HOLD, LOCKED. Reset state is HUNT. Counters: sh_cnt (0..SH_CNT_MAX), inv_cnt (0..SH_INVALID_MAX), wait_cnt (0..SLIP_WAIT).
- HUNT, on each valid block:
  - Valid header: sh_cnt++. When sh_cnt reaches SH_CNT_MAX, go to LOCKED and clear the counters.
  - Invalid header: pulse slip, clear sh_cnt, go to SLIP_HOLD.
- SLIP_HOLD:
  - Count valid blocks in wait_cnt; headers are not evaluated.
  - At SLIP_WAIT, clear wait_cnt and go to HUNT.
- LOCKED, on each valid block:
  - sh_cnt++; an invalid header also does inv_cnt++.
  - When inv_cnt reaches SH_INVALID_MAX, go to SLIP_HOLD, pulse slip, drop locked and clear the counters.
  - Otherwise, when sh_cnt reaches SH_CNT_MAX, clear sh_cnt and inv_cnt and stay LOCKED.
  - If both thresholds are hit on the same block, loss of lock wins.
- Cycles without data_valid: counters, state and s hold; valid_out, slip and header_err are 0.

## Timing
- Latency: all outputs are registered, with 1-cycle latency. A block accepted in cycle N appears on data_out/sync_out in cycle N+1.
- valid_out in N+1 = data_valid in N AND FSM state was LOCKED in cycle N (before that block's update).
  - The block that completes the lock-test window therefore does not produce valid_out.
  - The block that causes loss of lock still does produce valid_out.
- locked is asserted in the cycle after the transition into LOCKED and deasserted in the cycle after the transition out of it.
- slip and header_err are single-cycle pulses, aligned with the N+1 output of the triggering block.
- Reset values:
  - data_out = 0, sync_out = 0.
  - valid_out, slip, locked, header_err = 0.
  - s = all ones, state = HUNT, all counters 0.
- Reset mid-operation: rst_n low clears everything immediately (asynchronously). Release must be synchronized externally to clk.
- data_valid may be asserted every cycle; there is no backpressure.

## Test plan
- Reset: hold rst_n low with random data_in. Required: all outputs 0. After release with data_valid = 0, outputs stay 0 and locked = 0.
- Lock acquisition: a TX scrambler model (reset to all ones) drives 64 blocks with header 2'b01 and payload 0x0123456789ABCDEF, back to back. Required:
  - locked = 1 in the cycle after block 64 is accepted.
  - From block 65 on, valid_out = 1 and data_out = 0x0123456789ABCDEF.
- Misalignment: in HUNT, block 10 carries header 2'b11. Required:
  - slip = 1 for exactly one cycle and header_err pulses.
  - The next 32 valid blocks are ignored.
  - Lock needs a further 64 good headers; locked rises after block 10+32+64.
- Loss-of-lock threshold: while locked, inject 15 bad headers within one 64-header window. Required: locked stays 1 and header_err pulses 15 times. In the next window inject 16 bad headers: locked drops after the 16th, slip pulses once, and the state enters SLIP_HOLD.
- Descrambler self-sync: start the TX model with a random 58-bit seed while the DUT is at all ones. Required: after lock, every data_out equals the original TX payload; every output word from block 2 onward is correct.
- Gaps and reset: while locked, toggle data_valid randomly (about 50%). Required: output equals the ideal stream with gaps removed. Assert rst_n low mid-block. Required: locked, valid_out and data_out are 0 in the same cycle, and relock follows the normal sequence.
